// File: rtl/noc_local_injector_pkg.sv
// Shared types for the local-port injector: coordinates, flit preamble, FSM state, head fields.
package noc_local_injector_pkg;

   typedef logic [2:0] xy_t;

   typedef struct packed {
      logic head;
      logic tail;
   } preamble_t;

   typedef enum logic [0:0] {StIdle, StPayload} inj_state_t;

   // Wide enough for any practical MaxLen; zero-extension keeps the packed layout unchanged.
   localparam int unsigned HeadLenW = 8;

   typedef struct packed {
      logic [HeadLenW-1:0] len;
      logic [4:0]          msg_type;
      xy_t                 dest_y;
      xy_t                 dest_x;
      xy_t                 src_y;
      xy_t                 src_x;
   } head_fields_t;

endpackage

// File: rtl/noc_local_injector_if.sv
// Tile-side request/payload handshakes plus the router P-port flit link.
interface noc_local_injector_if
   import noc_local_injector_pkg::*;
#(
   parameter int unsigned Width  = 32,
   parameter int unsigned MaxLen = 15
) ();
   localparam int unsigned LenW = $clog2(MaxLen + 1);

   logic             req_valid;
   logic             req_ready;
   xy_t              req_dest_x;
   xy_t              req_dest_y;
   logic [4:0]       req_msg_type;
   logic [LenW-1:0]  req_len;
   logic             pld_valid;
   logic             pld_ready;
   logic [Width-3:0] pld_data;
   logic [Width-1:0] data_p_out;
   logic             data_void_p_out;
   logic             stop_p_in;

   modport master (
      output req_valid, req_dest_x, req_dest_y, req_msg_type, req_len,
      output pld_valid, pld_data, stop_p_in,
      input  req_ready, pld_ready, data_p_out, data_void_p_out
   );

   modport slave (
      input  req_valid, req_dest_x, req_dest_y, req_msg_type, req_len,
      input  pld_valid, pld_data, stop_p_in,
      output req_ready, pld_ready, data_p_out, data_void_p_out
   );
endinterface

// File: rtl/noc_flit_oreg.sv
// Single-entry flit output register with void flag; holds its contents while the router stops.
module noc_flit_oreg #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] flit_i,
   input  logic             stop_i,
   output logic             load_ok_o,
   output logic [Width-1:0] flit_o,
   output logic             void_o
);
   logic [Width-1:0] flit_q;
   logic             void_q;

   // Free when empty, or when the current flit leaves this cycle.
   assign load_ok_o = void_q | ~stop_i;
   assign flit_o    = flit_q;
   assign void_o    = void_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flit_q <= '0;
         void_q <= 1'b1;
      end else if (load_i) begin
         flit_q <= flit_i;
         void_q <= 1'b0;
      end else if (load_ok_o) begin
         void_q <= 1'b1;
      end
   end
endmodule

// File: rtl/noc_local_injector.sv
// Packetizer driving the router P port: head flit then payload flits, void/stop flow control.
// Optional NOC_INJ_PERF_CNT_EN adds perf_flits / perf_stall counters.
module noc_local_injector
   import noc_local_injector_pkg::*;
#(
   parameter int unsigned Width  = 32,
   parameter int unsigned MaxLen = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  xy_t                  CONST_localx,
   input  xy_t                  CONST_localy,
   noc_local_injector_if.slave  bus
`ifdef NOC_INJ_PERF_CNT_EN
   ,
   output logic [31:0]          perf_flits,
   output logic [31:0]          perf_stall
`endif
);
   localparam int unsigned LenW  = $clog2(MaxLen + 1);
   localparam int unsigned DataW = Width - 2;

   inj_state_t       state_q;
   logic [LenW-1:0]  rem_q;
   logic             run_q;
   logic             load_ok;
   logic             req_fire;
   logic             pld_fire;
   logic [LenW-1:0]  len_eff;
   head_fields_t     hf;
   preamble_t        pre;
   logic [DataW-1:0] body;
   logic [Width-1:0] flit_d;

   // run_q keeps both readies low until the first clock after reset.
   assign bus.req_ready = run_q & (state_q == StIdle) & load_ok;
   assign bus.pld_ready = run_q & (state_q == StPayload) & load_ok;
   assign req_fire      = bus.req_valid & bus.req_ready;
   assign pld_fire      = bus.pld_valid & bus.pld_ready;
   assign len_eff       = (32'(bus.req_len) > MaxLen) ? LenW'(MaxLen) : bus.req_len;

   always_comb begin
      hf          = '0;
      hf.src_x    = CONST_localx;
      hf.src_y    = CONST_localy;
      hf.dest_x   = bus.req_dest_x;
      hf.dest_y   = bus.req_dest_y;
      hf.msg_type = bus.req_msg_type;
      hf.len      = HeadLenW'(len_eff);
      if (state_q == StIdle) begin
         pre.head = 1'b1;
         pre.tail = (len_eff == '0);
         body     = DataW'(hf);
      end else begin
         pre.head = 1'b0;
         pre.tail = (rem_q == LenW'(1));
         body     = bus.pld_data;
      end
      flit_d = {pre, body};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         rem_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         run_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (req_fire) begin
                  rem_q <= len_eff;
                  if (len_eff != '0) state_q <= StPayload;
               end
            end
            StPayload: begin
               if (pld_fire) begin
                  rem_q <= rem_q - LenW'(1);
                  if (rem_q == LenW'(1)) state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   noc_flit_oreg #(
      .Width (Width)
   ) u_oreg (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (req_fire | pld_fire),
      .flit_i    (flit_d),
      .stop_i    (bus.stop_p_in),
      .load_ok_o (load_ok),
      .flit_o    (bus.data_p_out),
      .void_o    (bus.data_void_p_out)
   );

   len_legal_a: assert property (@(posedge clk) disable iff (rst)
      req_fire |-> (32'(bus.req_len) <= MaxLen));

`ifdef NOC_INJ_PERF_CNT_EN
   logic [31:0] perf_flits_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_flits_q <= '0;
         perf_stall_q <= '0;
      end else if (!bus.data_void_p_out) begin
         if (bus.stop_p_in) perf_stall_q <= perf_stall_q + 32'd1;
         else               perf_flits_q <= perf_flits_q + 32'd1;
      end
   end

   assign perf_flits = perf_flits_q;
   assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_noc_local_injector.sv
// Scoreboard bench for noc_local_injector: driver pushes expected flits, monitor pops on consume.
module tb_noc_local_injector;
   localparam int unsigned W  = 32;
   localparam int unsigned ML = 15;

   logic       clk;
   logic       rst;
   logic [2:0] locx;
   logic [2:0] locy;
`ifdef NOC_INJ_PERF_CNT_EN
   logic [31:0] perf_flits;
   logic [31:0] perf_stall;
`endif

   noc_local_injector_if #(.Width(W), .MaxLen(ML)) bus ();

   noc_local_injector #(
      .Width  (W),
      .MaxLen (ML)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .CONST_localx (locx),
      .CONST_localy (locy),
      .bus          (bus)
`ifdef NOC_INJ_PERF_CNT_EN
      ,
      .perf_flits   (perf_flits),
      .perf_stall   (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int              n_pass = 0;
   int              n_total = 0;
   int              cyc = 0;
   int              flit_cnt = 0;
   logic [W-1:0]    exp_q[$];
   int              cons_cyc[$];
   logic [W-3:0]    fixed_words[$];
   bit              stop_rand = 1'b0;
   bit              stall_arm = 1'b0;
   logic [W-3:0]    stall_word = '0;
   int              stall_left = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // Head flit assembled from the field layout with plain arithmetic.
   function automatic logic [W-1:0] head_model(input int sx, sy, dx, dy, ty, len);
      longint f;
      f = longint'(sx) + (longint'(sy) << 3) + (longint'(dx) << 6) + (longint'(dy) << 9)
          + (longint'(ty) << 12) + (longint'(len) << 17);
      return {1'b1, logic'(len == 0), f[W-3:0]};
   endfunction

   // Entered at a negedge with the request/payload already driven; returns just after the accepting edge.
   task automatic wait_hs(input bit is_req);
      int n = 0;
      bit hs = 1'b0;
      while (!hs) begin
         #2;
         hs = is_req ? (bus.req_ready === 1'b1) : (bus.pld_ready === 1'b1);
         @(posedge clk);
         if (!hs) begin
            n++;
            if (n > 2000) begin
               chk(is_req ? "req handshake timeout" : "pld handshake timeout", 0, 1);
               return;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic send_pkt(input int dx, dy, ty, len, gap_at, gap_len, n_send, input bit rand_gap);
      logic [W-3:0] words[$];
      logic [31:0]  r;
      int           g;
      for (int i = 0; i < len; i++) begin
         if (fixed_words.size() > 0) words.push_back(fixed_words.pop_front());
         else begin
            r = $urandom;
            words.push_back(r[W-3:0]);
         end
      end
      exp_q.push_back(head_model(int'(locx), int'(locy), dx, dy, ty, len));
      for (int i = 0; i < len; i++) exp_q.push_back({1'b0, logic'(i == len - 1), words[i]});
      @(negedge clk);
      bus.pld_valid    = 1'b0;
      bus.req_valid    = 1'b1;
      bus.req_dest_x   = 3'(dx);
      bus.req_dest_y   = 3'(dy);
      bus.req_msg_type = 5'(ty);
      bus.req_len      = 4'(len);
      wait_hs(1'b1);
      for (int i = 0; i < n_send; i++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         g = 0;
         if (i == gap_at) g = gap_len;
         else if (rand_gap && $urandom_range(3) == 0) g = int'($urandom_range(1, 3));
         if (g > 0) begin
            bus.pld_valid = 1'b0;
            repeat (g) @(negedge clk);
         end
         bus.pld_valid = 1'b1;
         bus.pld_data  = words[i];
         wait_hs(1'b0);
      end
   endtask

   task automatic idle_bus();
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.pld_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain scoreboard", 64'(exp_q.size()), 0);
   endtask

   // Router stop: directed 5-cycle stall on a chosen payload word, otherwise optional random.
   initial begin
      bus.stop_p_in = 1'b0;
      forever begin
         @(negedge clk);
         if (stall_left > 0) begin
            bus.stop_p_in = 1'b1;
            stall_left--;
         end else if (stall_arm && !bus.data_void_p_out && !bus.data_p_out[W-1]
                      && bus.data_p_out[W-3:0] == stall_word) begin
            bus.stop_p_in = 1'b1;
            stall_left    = 4;
            stall_arm     = 1'b0;
         end else begin
            bus.stop_p_in = stop_rand && ($urandom_range(3) == 0);
         end
      end
   end

   // Monitor: sampled mid-cycle, after the stop driver and before the next active edge.
   initial begin
      bit           prev_stall = 1'b0;
      logic [W-1:0] prev_flit = '0;
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            chk("hold void under stop", bus.data_void_p_out, 0);
            chk("hold flit under stop", bus.data_p_out, prev_flit);
         end
         if (!bus.data_void_p_out && bus.stop_p_in)
            chk("readies low while full and stopped", {bus.req_ready, bus.pld_ready}, 0);
         if (!bus.data_void_p_out && !bus.stop_p_in) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected flit: actual %0h required none", bus.data_p_out);
            end else begin
               e = exp_q.pop_front();
               chk("flit", bus.data_p_out, e);
            end
            cons_cyc.push_back(cyc);
            flit_cnt++;
         end
         prev_stall = !bus.data_void_p_out && bus.stop_p_in;
         prev_flit  = bus.data_p_out;
      end
   end

   initial begin
      int          n;
      int          flit_base;
      logic [31:0] stall0;
      rst = 1'b1;
      locx = '0;
      locy = '0;
      bus.req_valid = 1'b0;
      bus.req_dest_x = '0;
      bus.req_dest_y = '0;
      bus.req_msg_type = '0;
      bus.req_len = '0;
      bus.pld_valid = 1'b0;
      bus.pld_data = '0;
      stall0 = '0;
      flit_base = 0;
      #3;
      chk("reset void", bus.data_void_p_out, 1);
      chk("reset data", bus.data_p_out, 0);
      chk("reset req_ready", bus.req_ready, 0);
      chk("reset pld_ready", bus.pld_ready, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Head-only packet, local (0,0) -> (2,1), type 5.
      exp_q.push_back(head_model(0, 0, 2, 1, 5, 0));
      bus.req_valid = 1'b1;
      bus.req_dest_x = 3'd2;
      bus.req_dest_y = 3'd1;
      bus.req_msg_type = 5'd5;
      bus.req_len = 4'd0;
      #1;
      chk("pld_ready low in idle", bus.pld_ready, 0);
      chk("req_ready in idle", bus.req_ready, 1);
      wait_hs(1'b1);
      #1;
      chk("head latency void", bus.data_void_p_out, 0);
      chk("head-only flit", bus.data_p_out, head_model(0, 0, 2, 1, 5, 0));
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("void after head-only", bus.data_void_p_out, 1);
      drain();

      // Three payload words back to back.
      fixed_words = '{30'hA, 30'hB, 30'hC};
      send_pkt(1, 2, 3, 3, -1, 0, 3, 1'b0);
      idle_bus();
      drain();
      n = cons_cyc.size();
      chk("4 flits consecutive", 64'(cons_cyc[n-1] - cons_cyc[n-4]), 3);

      // Five-cycle stall on the second payload flit.
`ifdef NOC_INJ_PERF_CNT_EN
      stall0 = perf_stall;
`endif
      fixed_words = '{30'h11, 30'h22, 30'h33};
      stall_word = 30'h22;
      stall_arm = 1'b1;
      send_pkt(4, 5, 6, 3, -1, 0, 3, 1'b0);
      idle_bus();
      drain();
      chk("stall was applied", stall_arm, 0);
      n = cons_cyc.size();
      chk("stall spacing", 64'(cons_cyc[n-1] - cons_cyc[n-3]), 7);
`ifdef NOC_INJ_PERF_CNT_EN
      chk("perf_stall delta", perf_stall - stall0, 5);
`endif

      // Payload gap of 3 cycles before the last word.
      fixed_words = '{30'h1, 30'h2, 30'h3};
      send_pkt(7, 0, 9, 3, 2, 3, 3, 1'b0);
      idle_bus();
      drain();
      n = cons_cyc.size();
      chk("gap of 3 void cycles", 64'(cons_cyc[n-1] - cons_cyc[n-2]), 4);

      // Back-to-back len=1 then len=0.
      fixed_words = '{30'h5};
      send_pkt(3, 3, 1, 1, -1, 0, 1, 1'b0);
      send_pkt(6, 2, 2, 0, -1, 0, 0, 1'b0);
      idle_bus();
      drain();
      n = cons_cyc.size();
      chk("back-to-back no bubble", 64'(cons_cyc[n-1] - cons_cyc[n-3]), 2);

      // Asynchronous reset in the middle of a 5-word packet.
      send_pkt(2, 2, 7, 5, -1, 0, 2, 1'b0);
      idle_bus();
      #1;
      rst = 1'b1;
      flit_base = flit_cnt;
      #1;
      chk("async reset void", bus.data_void_p_out, 1);
      chk("async reset data", bus.data_p_out, 0);
      chk("async reset req_ready", bus.req_ready, 0);
      chk("async reset pld_ready", bus.pld_ready, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send_pkt(3, 4, 9, 0, -1, 0, 0, 1'b0);
      idle_bus();
      drain();

      // Randomized traffic with random stop and payload gaps.
      locx = 3'($urandom_range(7));
      locy = 3'($urandom_range(7));
      stop_rand = 1'b1;
      for (int p = 0; p < 40; p++) begin
         n = int'($urandom_range(0, ML));
         send_pkt(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(31)),
                  n, -1, 0, n, 1'b1);
         if ($urandom_range(3) == 0) begin
            idle_bus();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      idle_bus();
      drain();
      stop_rand = 1'b0;
      repeat (3) @(negedge clk);
`ifdef NOC_INJ_PERF_CNT_EN
      chk("perf_flits total", perf_flits, 64'(flit_cnt - flit_base));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
